calc_alu_seq: RTL and testbench
===============================

// Module: calc_alu_seq
// PURPOSE
//  Parametrised, handshaked successor of the calculator's 4-bit combinational ALU.
//  Registers operands and runs 8 operations, including iterative multiply and divide.
//  Returns result, high word/remainder and status flags over a valid/ready interface.
//  Sits between the calculator input decoder and the display/result formatter.
// PARAMETERS
//  WIDTH   4   operand/result width in bits (>=2)
//  CNT_W   $clog2(WIDTH+1)   iteration counter width (derived, not overridden)
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      synchronous reset, active-low
//  in_valid    in   1      operand/op request valid
//  in_ready    out  1      block can accept a request
//  alu_op      in   3      op code (see BEHAVIOUR)
//  a           in   WIDTH  operand A (unsigned; signed view for ovf only)
//  b           in   WIDTH  operand B
//  use_acc     in   1      only when CALC_ALU_ACC_EN defined: A := accumulator
//  out_valid   out  1      result valid
//  out_ready   in   1      consumer takes result
//  result      out  WIDTH  low result / quotient
//  result_hi   out  WIDTH  MUL high word / DIV remainder; 0 for other ops
//  flag_zero   out  1      result == 0
//  flag_carry  out  1      ADD carry-out / SUB borrow (a<b); 0 otherwise
//  flag_ovf    out  1      ADD/SUB signed overflow; MUL result_hi!=0; 0 otherwise
//  flag_dbz    out  1      DIV with b==0
// BEHAVIOUR
//  Ops: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL, 110 DIV, 111 NOT A.
//  FSM: IDLE -> (accept) -> EXEC (MUL/DIV only) -> DONE -> (out handshake) -> IDLE.
//  - in_ready = 1 only in IDLE; accept = in_valid & in_ready; operands/op latched.
//  - Simple ops (ADD..XOR, NOT, DIV b==0): result computed at accept; DONE next cycle.
//    Latency accept->out_valid = 1 cycle.
//  - MUL: shift-add, one bit per cycle, WIDTH cycles in EXEC.
//    out_valid exactly WIDTH+1 cycles after accept.
//  - DIV: restoring, one bit per cycle, WIDTH cycles; same latency as MUL.
//  - DIV b==0: skip EXEC; result = all ones, result_hi = a, flag_dbz = 1.
//  - ADD/SUB: WIDTH-bit wrap; carry from WIDTH+1-bit sum/difference.
//  - DONE: out_valid = 1; all outputs held stable until out_valid & out_ready.
//    Then state -> IDLE and out_valid = 0.
//    in_ready rises the cycle after the handshake; no same-cycle bypass.
//  - in_valid outside IDLE is ignored (no queueing).
//  - Invalid op codes: none (all 8 codes defined).
//  - Reset (rst_n=0 at clk edge), including mid-EXEC: state IDLE, counter 0.
//    Operation abandoned. Outputs after reset:
//    in_ready=1, out_valid=0, result/result_hi=0, all flags=0.
// CONFIGURATION
//  CALC_ALU_ACC_EN defined:
//   - use_acc port exists; WIDTH-bit accumulator register, reset 0.
//   - Accumulator loads result at each out handshake.
//   - use_acc=1 at accept: latched A = accumulator; port a ignored.
//  Not defined: no use_acc port, no accumulator; A always taken from port a.
// TESTING (WIDTH=4)
//  1. ADD a=9 b=8 -> 1 cycle later: out_valid=1, result=1, carry=1, ovf=1, zero=0.
//     SUB a=3 b=5 -> result=4'hE, carry=1, ovf=0.
//  2. MUL a=15 b=15 -> out_valid at accept+5: result=4'h1, result_hi=4'hE, ovf=1.
//     MUL a=3 b=0 -> result=0, zero=1, ovf=0.
//  3. DIV a=13 b=4 -> at accept+5: result=3, result_hi=1, dbz=0.
//     DIV a=13 b=0 -> at accept+1: result=4'hF, result_hi=4'hD, dbz=1.
//  4. Backpressure: hold out_ready=0 for 3 cycles after XOR a=5 b=3.
//     -> result=6 stable, in_ready=0, a concurrent in_valid request is dropped.
//  5. rst_n=0 for one edge during MUL (2 cycles into EXEC).
//     -> next cycle: in_ready=1, out_valid=0, outputs 0; new ADD 1+1 gives 2.
//  6. CALC_ALU_ACC_EN: ADD 2+3 (result 5, consumed), then use_acc=1 ADD b=4.
//     -> result=9. Without macro: same sequence using a=2 gives 6.

Source files
------------

// File: rtl/calc_alu_seq.sv
// Handshaked sequential calculator ALU: 8 ops with iterative shift-add MUL and restoring DIV.
// Optional accumulator operand source enabled by defining CALC_ALU_ACC_EN.
module calc_alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef CALC_ALU_ACC_EN
  input  logic             use_acc,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             flag_dbz
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;
  localparam logic [2:0] OP_DIV = 3'd6;
  localparam logic [2:0] OP_NOT = 3'd7;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] src_q, src_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             dbz_q, dbz_d;
`ifdef CALC_ALU_ACC_EN
  logic [WIDTH-1:0] acc_q, acc_d;
`endif

  logic [WIDTH-1:0] a_eff;
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [WIDTH-1:0] simple_res;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_rem_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_trial;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

`ifdef CALC_ALU_ACC_EN
  assign a_eff = use_acc ? acc_q : a;
`else
  assign a_eff = a;
`endif

  assign add_w = {1'b0, a_eff} + {1'b0, b};
  assign sub_w = {1'b0, a_eff} - {1'b0, b};

  always_comb begin
    simple_res = '0;
    case (alu_op)
      OP_ADD:  simple_res = add_w[WIDTH-1:0];
      OP_SUB:  simple_res = sub_w[WIDTH-1:0];
      OP_AND:  simple_res = a_eff & b;
      OP_OR:   simple_res = a_eff | b;
      OP_XOR:  simple_res = a_eff ^ b;
      OP_NOT:  simple_res = ~a_eff;
      default: simple_res = '0;
    endcase
  end

  // One iteration of either algorithm; only the one matching op_q is used.
  // The remainder stays below the divisor, so a WIDTH-bit trial difference is exact.
  always_comb begin
    mul_sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, src_q} : '0);
    div_rem_sh = {hi_q, lo_q[WIDTH-1]};
    div_ge     = div_rem_sh >= {1'b0, src_q};
    div_trial  = div_rem_sh[WIDTH-1:0] - src_q;
    if (op_q == OP_MUL) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else begin
      step_hi = div_ge ? div_trial : div_rem_sh[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], div_ge};
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    src_d       = src_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    dbz_d       = dbz_q;
`ifdef CALC_ALU_ACC_EN
    acc_d       = acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d  = alu_op;
          cnt_d = '0;
          if (alu_op == OP_MUL) begin
            src_d   = a_eff;
            lo_d    = b;
            hi_d    = '0;
            state_d = EXEC;
          end else if (alu_op == OP_DIV && b != '0) begin
            src_d   = b;
            lo_d    = a_eff;
            hi_d    = '0;
            state_d = EXEC;
          end else if (alu_op == OP_DIV) begin
            result_d    = '1;
            result_hi_d = a_eff;
            zero_d      = 1'b0;
            carry_d     = 1'b0;
            ovf_d       = 1'b0;
            dbz_d       = 1'b1;
            state_d     = DONE;
          end else begin
            result_d    = simple_res;
            result_hi_d = '0;
            zero_d      = (simple_res == '0);
            carry_d     = 1'b0;
            ovf_d       = 1'b0;
            dbz_d       = 1'b0;
            if (alu_op == OP_ADD) begin
              carry_d = add_w[WIDTH];
              ovf_d   = (a_eff[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a_eff[WIDTH-1]);
            end else if (alu_op == OP_SUB) begin
              carry_d = sub_w[WIDTH];
              ovf_d   = (a_eff[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a_eff[WIDTH-1]);
            end
            state_d = DONE;
          end
        end
      end
      EXEC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          result_d    = step_lo;
          result_hi_d = step_hi;
          zero_d      = (step_lo == '0);
          carry_d     = 1'b0;
          ovf_d       = (op_q == OP_MUL) && (step_hi != '0);
          dbz_d       = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
`ifdef CALC_ALU_ACC_EN
          acc_d   = result_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      src_q       <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
`ifdef CALC_ALU_ACC_EN
      acc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      src_q       <= src_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      dbz_q       <= dbz_d;
`ifdef CALC_ALU_ACC_EN
      acc_q       <= acc_d;
`endif
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign result     = result_q;
  assign result_hi  = result_hi_q;
  assign flag_zero  = zero_q;
  assign flag_carry = carry_q;
  assign flag_ovf   = ovf_q;
  assign flag_dbz   = dbz_q;

endmodule

// File: tb/tb_calc_alu_seq.sv
// Self-checking bench for calc_alu_seq (WIDTH=4): directed cases plus random ops against
// an arithmetic reference model; honours CALC_ALU_ACC_EN when defined.
module tb_calc_alu_seq;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_AND = 2;
  localparam int OP_OR  = 3;
  localparam int OP_XOR = 4;
  localparam int OP_MUL = 5;
  localparam int OP_DIV = 6;
  localparam int OP_NOT = 7;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   alu_op;
  logic [W-1:0] a;
  logic [W-1:0] b;
`ifdef CALC_ALU_ACC_EN
  logic         use_acc;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         flag_zero;
  logic         flag_carry;
  logic         flag_ovf;
  logic         flag_dbz;

  int checkCount = 0;
  int errorCount = 0;
  int accModel   = 0;
  int lastResult = 0;

  calc_alu_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_op     (alu_op),
    .a          (a),
    .b          (b),
`ifdef CALC_ALU_ACC_EN
    .use_acc    (use_acc),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .result_hi  (result_hi),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .flag_ovf   (flag_ovf),
    .flag_dbz   (flag_dbz)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual != expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int sval(input int x);
    return (x >= (1 << (W - 1))) ? x - (1 << W) : x;
  endfunction

  // Reference behaviour written directly from the arithmetic meaning of each op.
  task automatic modelOp(input int op, input int av, input int bv,
                         output int r, output int rh, output int z, output int c,
                         output int o, output int d, output int lat);
    int s;
    rh = 0; c = 0; o = 0; d = 0; lat = 1; r = 0;
    case (op)
      OP_ADD: begin
        r = (av + bv) & MASK;
        c = (av + bv) > MASK;
        s = sval(av) + sval(bv);
        o = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
      end
      OP_SUB: begin
        r = (av - bv) & MASK;
        c = av < bv;
        s = sval(av) - sval(bv);
        o = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
      end
      OP_AND: r = av & bv;
      OP_OR:  r = av | bv;
      OP_XOR: r = av ^ bv;
      OP_NOT: r = MASK - av;
      OP_MUL: begin
        r   = (av * bv) & MASK;
        rh  = (av * bv) >> W;
        o   = rh != 0;
        lat = W + 1;
      end
      default: begin
        if (bv == 0) begin
          r = MASK;
          rh = av;
          d = 1;
        end else begin
          r   = av / bv;
          rh  = av % bv;
          lat = W + 1;
        end
      end
    endcase
    z = (r == 0);
  endtask

  task automatic applyStimulus(input int op, input int av, input int bv);
    int guard = 0;
    while (!in_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) checkOutput("in_ready_timeout", 0, 1);
    in_valid = 1'b1;
    alu_op   = op[2:0];
    a        = av[W-1:0];
    b        = bv[W-1:0];
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic waitResult(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic runOp(input int op, input int av, input int bv, input bit useAcc, input int hold);
    int eR, eH, eZ, eC, eO, eD, eLat, lat, aEff;
    aEff = useAcc ? accModel : av;
    modelOp(op, aEff, bv, eR, eH, eZ, eC, eO, eD, eLat);
`ifdef CALC_ALU_ACC_EN
    use_acc = useAcc;
`endif
    applyStimulus(op, av, bv);
`ifdef CALC_ALU_ACC_EN
    use_acc = 1'b0;
`endif
    waitResult(lat);
    checkOutput("latency", lat, eLat);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("hold_valid", out_valid, 1);
      checkOutput("hold_result", result, eR);
    end
    checkOutput("result", result, eR);
    checkOutput("result_hi", result_hi, eH);
    checkOutput("flag_zero", flag_zero, eZ);
    checkOutput("flag_carry", flag_carry, eC);
    checkOutput("flag_ovf", flag_ovf, eO);
    checkOutput("flag_dbz", flag_dbz, eD);
    lastResult = result;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("out_valid_after_hs", out_valid, 0);
    checkOutput("in_ready_after_hs", in_ready, 1);
    accModel = eR;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_in_ready"}, in_ready, 1);
    checkOutput({tag, "_out_valid"}, out_valid, 0);
    checkOutput({tag, "_result"}, result, 0);
    checkOutput({tag, "_result_hi"}, result_hi, 0);
    checkOutput({tag, "_flags"}, {flag_zero, flag_carry, flag_ovf, flag_dbz}, 0);
  endtask

  initial begin
    int op, av, bv;
    bit ua;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    alu_op    = '0;
    a         = '0;
    b         = '0;
`ifdef CALC_ALU_ACC_EN
    use_acc   = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checkResetState("reset");

    runOp(OP_ADD, 9, 8, 0, 0);
    checkOutput("add_9_8", lastResult, 1);
    runOp(OP_SUB, 3, 5, 0, 0);
    checkOutput("sub_3_5", lastResult, 14);
    runOp(OP_MUL, 15, 15, 0, 0);
    checkOutput("mul_15_15", lastResult, 1);
    runOp(OP_MUL, 3, 0, 0, 0);
    runOp(OP_DIV, 13, 4, 0, 0);
    checkOutput("div_13_4", lastResult, 3);
    runOp(OP_DIV, 13, 0, 0, 0);
    checkOutput("div_13_0", lastResult, 15);
    runOp(OP_NOT, 10, 0, 0, 0);

    // Backpressure: result must hold while a competing request is ignored.
    applyStimulus(OP_XOR, 5, 3);
    checkOutput("bp_valid", out_valid, 1);
    in_valid = 1'b1;
    alu_op   = 3'(OP_ADD);
    a        = 4'd7;
    b        = 4'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_result", result, 6);
      checkOutput("bp_in_ready", in_ready, 0);
      checkOutput("bp_out_valid", out_valid, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("bp_in_ready_after", in_ready, 1);
    @(negedge clk);
    checkOutput("bp_dropped", out_valid, 0);
    accModel = 6;

    // Reset two cycles into a multiply abandons it.
    applyStimulus(OP_MUL, 7, 9);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkResetState("midexec");
    accModel = 0;
    runOp(OP_ADD, 1, 1, 0, 0);
    checkOutput("add_after_reset", lastResult, 2);

    runOp(OP_ADD, 2, 3, 0, 0);
`ifdef CALC_ALU_ACC_EN
    runOp(OP_ADD, 0, 4, 1, 0);
    checkOutput("acc_chain", lastResult, 9);
`else
    runOp(OP_ADD, 2, 4, 0, 0);
    checkOutput("acc_chain", lastResult, 6);
`endif

    for (int n = 0; n < 60; n++) begin
      op = int'($urandom_range(0, 7));
      av = int'($urandom_range(0, MASK));
      bv = int'($urandom_range(0, MASK));
      if (op == OP_DIV && $urandom_range(0, 3) == 0) bv = 0;
      ua = 1'b0;
`ifdef CALC_ALU_ACC_EN
      ua = 1'($urandom_range(0, 1));
`endif
      runOp(op, av, bv, ua, int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
